seq_shift_left: RTL and testbench
=================================

// Module: seq_shift_left
// PURPOSE
//  Multi-cycle left shifter/rotator for the CPU datapath ALU; the left-direction counterpart of the right shifter.
//  Shifts operand y left by amt positions, one bit per clock, then drives the result onto the Zlow/Zhigh pair.
//  Zlow carries the shifted word; Zhigh collects the bits shifted out.
//  Start/busy/done handshake lets the control unit stall until the result is valid.
// PARAMETERS
//  WIDTH  32               operand width; Zlow and Zhigh are each WIDTH bits
//  AMT_W  $clog2(WIDTH)    width of the shift-amount input (5 for WIDTH=32)
// PORTS
//  clock   in   1      single clock; all state updates on rising edge
//  clear   in   1      synchronous, active-high reset
//  start   in   1      request; sampled only in IDLE
//  y       in   WIDTH  operand to shift
//  amt     in   AMT_W  shift count, 0..WIDTH-1 (taken from low bits of the count register)
//  rotate  in   1      1 = rotate left, 0 = logical shift left (honoured only with ROTATE_EN)
//  busy    out  1      high while a request is in progress (SHIFT or DONE)
//  done    out  1      single-cycle pulse: Zlow/Zhigh hold the final result
//  Zlow    out  WIDTH  shifted/rotated operand
//  Zhigh   out  WIDTH  bits shifted out of Zlow's MSB; all zero for rotate
// BEHAVIOUR
//  Reset: clock and clear are as stated above (one clock; clear synchronous, active-high).
//   clear=1 at an edge -> state IDLE, cnt=0; busy=0, done=0, Zlow=0, Zhigh=0. Takes priority over all else.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : start=1 -> Zlow<=y, Zhigh<=0, cnt<=amt, mode<=rotate; next SHIFT if amt!=0, else DONE.
//   SHIFT: per edge, one 1-bit step, cnt<=cnt-1; cnt==1 at the edge -> next DONE.
//   DONE : done=1 for this cycle only; next IDLE.
//  Step, logical: {Zhigh,Zlow} <= {Zhigh,Zlow} << 1, LSB filled with 0.
//  Step, rotate : Zlow <= {Zlow[WIDTH-2:0], Zlow[WIDTH-1]}; Zhigh stays 0.
//  Latency: done is high in the cycle following edge max(amt,1), counted from the edge that samples start.
//   amt=0 -> done after 1 cycle; amt=31 -> done after 31 cycles.
//  busy = (state != IDLE), decoded from registered state. Zlow/Zhigh are registered, and are valid only when done=1.
//  After DONE, Zlow/Zhigh hold their value until the next accepted start or clear.
//  start while busy is ignored: no queueing, and y/amt/rotate changes have no effect.
//  start in the same cycle as done is ignored. The earliest new acceptance is the following (IDLE) cycle.
//  The control unit must hold start for one cycle only. A start held high is re-accepted on every IDLE cycle.
//  clear mid-operation aborts: no done pulse, outputs forced to 0.
// CONFIGURATION
//  ROTATE_EN defined  : rotate input is captured at start and selects the rotate step.
//  ROTATE_EN undefined: rotate is ignored and mode is forced to logical shift.
//   The rotate port is kept for interface stability.
//   The mode register and rotate mux are not generated.
// STRUCTURE
//  Package cpu_shift_pkg holds:
//   - enum shift_state_t {IDLE, SHIFT, DONE};
//   - localparam SHIFT_W = 32;
//   - mode constants MODE_SHL=1'b0, MODE_ROL=1'b1.
//  Sub-module shift_step: combinational one-bit step.
//   Inputs {hi, lo, mode}; outputs {hi_n, lo_n}.
//   Instantiated once; the FSM, counter and registers live in seq_shift_left.
// TESTING
//  1 clear asserted during SHIFT (y=32'hFFFF_FFFF, amt=20, clear at cycle 5)
//    -> IDLE next cycle; Zlow=Zhigh=0; busy=0; no done pulse.
//  2 y=32'h8000_0001, amt=1, rotate=0
//    -> done after 1 cycle; Zlow=32'h0000_0002, Zhigh=32'h0000_0001.
//  3 y=32'h1234_5678, amt=0
//    -> done after 1 cycle; Zlow=32'h1234_5678, Zhigh=0; busy high for 1 cycle.
//  4 y=32'hF000_000F, amt=4, rotate=1, with ROTATE_EN defined
//    -> done after 4 cycles; Zlow=32'h0000_00FF, Zhigh=0.
//    Without ROTATE_EN -> Zlow=32'h0000_00F0, Zhigh=32'h0000_000F.
//  5 y=32'h0000_0001, amt=31; pulse start again at cycle 10
//    -> second start ignored; done after 31 cycles; Zlow=32'h8000_0000, Zhigh=0; done width = 1 cycle.
//  6 back-to-back: start held high
//    -> done pulse, one IDLE cycle, re-acceptance; each result matches a reference model y<<amt.

Source files
------------

// File: rtl/cpu_shift_pkg.sv
// Shared types and constants for the multi-cycle ALU shifter.
package cpu_shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  localparam int SHIFT_W = 32;

  localparam logic MODE_SHL = 1'b0;
  localparam logic MODE_ROL = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit left step on the {hi, lo} pair.
// Rotate mode exists only when ROTATE_EN is defined.
module shift_step
  import cpu_shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_W
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic             mode,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  always_comb begin
    hi_n = {hi[WIDTH-2:0], lo[WIDTH-1]};
    lo_n = {lo[WIDTH-2:0], 1'b0};
`ifdef ROTATE_EN
    // Rotating recirculates the MSB into the LSB and leaves hi untouched.
    if (mode == MODE_ROL) begin
      hi_n = hi;
      lo_n = {lo[WIDTH-2:0], lo[WIDTH-1]};
    end
`endif
  end

`ifndef ROTATE_EN
  logic modeUnused;
  assign modeUnused = mode;
`endif

endmodule

// File: rtl/seq_shift_left.sv
// Multi-cycle left shifter/rotator with start/busy/done handshake.
// Define ROTATE_EN to enable the rotate-left mode.
module seq_shift_left
  import cpu_shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_W,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] y,
  input  logic [AMT_W-1:0] amt,
  input  logic             rotate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Zlow,
  output logic [WIDTH-1:0] Zhigh
);

  shift_state_t     state_q;
  logic [AMT_W-1:0] cnt_q;
  logic [WIDTH-1:0] zlow_q, zhigh_q;
  logic [WIDTH-1:0] zlow_d, zhigh_d;
  logic             mode;

`ifdef ROTATE_EN
  logic mode_q;
  assign mode = mode_q;
`else
  logic rotateUnused;
  assign rotateUnused = rotate;
  assign mode         = MODE_SHL;
`endif

  shift_step #(.WIDTH(WIDTH)) u_step (
    .hi   (zhigh_q),
    .lo   (zlow_q),
    .mode (mode),
    .hi_n (zhigh_d),
    .lo_n (zlow_d)
  );

  // Control FSM: capture in IDLE, one step per clock in SHIFT, pulse in DONE.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      zlow_q  <= '0;
      zhigh_q <= '0;
`ifdef ROTATE_EN
      mode_q  <= MODE_SHL;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            zlow_q  <= y;
            zhigh_q <= '0;
            cnt_q   <= amt;
`ifdef ROTATE_EN
            mode_q  <= rotate;
`endif
            state_q <= (amt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          zlow_q  <= zlow_d;
          zhigh_q <= zhigh_d;
          cnt_q   <= cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign Zlow  = zlow_q;
  assign Zhigh = zhigh_q;

endmodule

// File: tb/tb_seq_shift_left.sv
// Self-checking bench for seq_shift_left: directed cases plus random vectors against a {hi,lo} model.
module tb_seq_shift_left;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clock = 1'b0;
  logic          clear, start, rotate;
  logic [W-1:0]  y;
  logic [AW-1:0] amt;
  logic          busy, done;
  logic [W-1:0]  Zlow, Zhigh;

  int vectors     = 0;
  int miscompares = 0;

  seq_shift_left #(.WIDTH(W), .AMT_W(AW)) dut (
    .clock  (clock),
    .clear  (clear),
    .start  (start),
    .y      (y),
    .amt    (amt),
    .rotate (rotate),
    .busy   (busy),
    .done   (done),
    .Zlow   (Zlow),
    .Zhigh  (Zhigh)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result as {Zhigh, Zlow}: a double-width shift; rotation folds the overflow back in.
  function automatic logic [63:0] refModel(input logic [W-1:0] op, input int n, input logic rot);
    logic [63:0] wide;
    logic        useRot;
    wide   = {32'b0, op} << n;
    useRot = rot;
`ifndef ROTATE_EN
    useRot = 1'b0;
`endif
    if (useRot) return {32'b0, wide[31:0] | wide[63:32]};
    return wide;
  endfunction

  // Pulses start for one cycle, waits for done, checks latency, result and pulse width.
  // intrudeAt >= 0 pulses a second start with different operands while the first is busy.
  task automatic applyStimulus(input string tag, input logic [W-1:0] op, input logic [AW-1:0] n,
                               input logic rot, input int intrudeAt);
    logic [63:0] exp;
    int          cycles;
    exp = refModel(op, int'(n), rot);
    @(negedge clock);
    y = op; amt = n; rotate = rot; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput({tag, " busy"}, 64'(busy), 64'(1));
    cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge clock);
      cycles++;
      if (cycles == intrudeAt) begin
        start = 1'b1; y = ~op; amt = 5'd3; rotate = ~rot;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, 64'(cycles), 64'(n));
    checkOutput({tag, " result"}, {Zhigh, Zlow}, exp);
    @(negedge clock);
    checkOutput({tag, " pulse"}, {62'b0, done, busy}, 64'(0));
    checkOutput({tag, " hold"}, {Zhigh, Zlow}, exp);
  endtask

  initial begin
    logic [W-1:0]  ry;
    logic [AW-1:0] ra;
    logic          rr;
    int            cycles;
    logic          sawDone;
    logic [W-1:0]  bY [3];
    logic [AW-1:0] bA [3];

    clear = 1'b1; start = 1'b0; y = '0; amt = '0; rotate = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset", {Zhigh, Zlow}, 64'(0));
    checkOutput("reset ctl", {62'b0, busy, done}, 64'(0));
    clear = 1'b0;

    // Case 1: clear during SHIFT aborts with no done pulse.
    @(negedge clock);
    y = 32'hFFFF_FFFF; amt = 5'd20; rotate = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checkOutput("clr regs", {Zhigh, Zlow}, 64'(0));
    checkOutput("clr ctl", {62'b0, busy, done}, 64'(0));
    sawDone = 1'b0;
    repeat (25) begin
      @(negedge clock);
      if (done) sawDone = 1'b1;
    end
    checkOutput("clr nodone", 64'(sawDone), 64'(0));

    // Cases 2-5, with the spec's literal results for the fixed-mode cases.
    applyStimulus("t2", 32'h8000_0001, 5'd1, 1'b0, -1);
    checkOutput("t2 const", {Zhigh, Zlow}, {32'h0000_0001, 32'h0000_0002});
    applyStimulus("t3", 32'h1234_5678, 5'd0, 1'b0, -1);
    checkOutput("t3 const", {Zhigh, Zlow}, {32'h0, 32'h1234_5678});
    applyStimulus("t4", 32'hF000_000F, 5'd4, 1'b1, -1);
`ifdef ROTATE_EN
    checkOutput("t4 const", {Zhigh, Zlow}, {32'h0, 32'h0000_00FF});
`else
    checkOutput("t4 const", {Zhigh, Zlow}, {32'h0000_000F, 32'h0000_00F0});
`endif
    applyStimulus("t5", 32'h0000_0001, 5'd31, 1'b0, 10);
    checkOutput("t5 const", {Zhigh, Zlow}, {32'h0, 32'h8000_0000});

    // Case 6: start held high; each result re-accepted after one IDLE cycle.
    bY[0] = $urandom; bA[0] = 5'($urandom_range(1, 31));
    bY[1] = $urandom; bA[1] = 5'd0;
    bY[2] = $urandom; bA[2] = 5'($urandom_range(1, 31));
    @(negedge clock);
    y = bY[0]; amt = bA[0]; rotate = 1'b0; start = 1'b1;
    @(negedge clock);
    cycles = 0;
    while (!done && cycles < 100) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput("b2b0 latency", 64'(cycles), 64'(bA[0]));
    checkOutput("b2b0 result", {Zhigh, Zlow}, refModel(bY[0], int'(bA[0]), 1'b0));
    for (int k = 1; k < 3; k++) begin
      y = bY[k]; amt = bA[k];
      @(negedge clock);
      checkOutput($sformatf("b2b%0d idle", k), {62'b0, busy, done}, 64'(0));
      @(negedge clock);
      cycles = 0;
      while (!done && cycles < 100) begin
        @(negedge clock);
        cycles++;
      end
      checkOutput($sformatf("b2b%0d latency", k), 64'(cycles), 64'(bA[k]));
      checkOutput($sformatf("b2b%0d result", k), {Zhigh, Zlow}, refModel(bY[k], int'(bA[k]), 1'b0));
    end
    start = 1'b0;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 24; i++) begin
      ry = $urandom;
      ra = 5'($urandom_range(0, 31));
      rr = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rnd%0d", i), ry, ra, rr, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
